grad_window_gen: RTL

- Producer for the non-maximum-suppression stage. Takes a raster stream of 26-bit gradient words: [25:24] direction, [23:0] squared magnitude.
- Buffers two previous image rows and presents a 3x3 gradient window (grad_p11..grad_p33) with a one-cycle start strobe.
- Emits one strobe per interior pixel, so border pixels never reach the suppression stage.
- Has no backpressure, because the downstream stage accepts one window per cycle unconditionally.

---
 rtl/canny_pkg.sv | 40 ++++
 rtl/line_buf.sv | 54 +++++
 rtl/grad_window_gen.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/canny_pkg.sv
// Shared definitions for the Canny edge pipeline: gradient word layout,
// direction codes and default image geometry.
package canny_pkg;

    // Gradient word: [25:24] direction, [23:0] squared magnitude
    localparam int DATA_W    = 26;
    localparam int MAG_W     = 24;
    localparam int MAG_MSB   = 23;
    localparam int MAG_LSB   = 0;
    localparam int DIR_MSB   = 25;
    localparam int DIR_LSB   = 24;

    // Default frame geometry
    localparam int IMG_W_DEF = 512;
    localparam int IMG_H_DEF = 636;

    // Quantised gradient direction
    typedef enum logic [1:0] {
        DIR_N  = 2'b00,
        DIR_E  = 2'b01,
        DIR_NW = 2'b10,
        DIR_NE = 2'b11
    } grad_dir_t;

    typedef struct packed {
        grad_dir_t         dir;
        logic [MAG_W-1:0]  mag;
    } grad_word_t;

    // Extract the direction field of a gradient word
    function automatic grad_dir_t grad_dir(input logic [DATA_W-1:0] word);
        return grad_dir_t'(word[DIR_MSB:DIR_LSB]);
    endfunction

    // Extract the squared-magnitude field of a gradient word
    function automatic logic [MAG_W-1:0] grad_mag(input logic [DATA_W-1:0] word);
        return word[MAG_MSB:MAG_LSB];
    endfunction

endpackage

// File: rtl/line_buf.sv
// One image row of storage: single-port RAM, synchronous read-before-write.
// rd_data is the registered word that sat at addr before the write; rd_old
// exposes that same pre-write word during the access cycle so a second
// buffer chained behind this one can capture it at the same edge.
module line_buf
    import canny_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF,
    parameter int WIDTH = canny_pkg::DATA_W,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rd_old,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    // Row storage; contents are deliberately left uninitialised on reset
    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[addr] <= wdata;
        end
    end

    // Pre-write word at the current address, and read-data next state
    always_comb begin
        rd_old    = mem_q[addr];
        rd_data_d = rd_data_q;
        if (en) begin
            rd_data_d = mem_q[addr];
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= {WIDTH{1'b0}};
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/grad_window_gen.sv
// 3x3 gradient window producer for non-maximum suppression. Buffers two rows,
// shifts a window per accepted pixel, and strobes start only for interior
// centres. Stage 1 captures position flags alongside the line-buffer reads;
// stage 2 shifts the window and raises start/frame_done.
module grad_window_gen
    import canny_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int DATA_W = canny_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] grad_p11,
    output logic [DATA_W-1:0] grad_p12,
    output logic [DATA_W-1:0] grad_p13,
    output logic [DATA_W-1:0] grad_p21,
    output logic [DATA_W-1:0] grad_p22,
    output logic [DATA_W-1:0] grad_p23,
    output logic [DATA_W-1:0] grad_p31,
    output logic [DATA_W-1:0] grad_p32,
    output logic [DATA_W-1:0] grad_p33,
    output logic              start,
    output logic              frame_done
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(32'd1);
    localparam logic [YW-1:0] Y_ONE  = YW'(32'd1);
    localparam logic [XW-1:0] X_TWO  = XW'(32'd2);
    localparam logic [YW-1:0] Y_TWO  = YW'(32'd2);

    logic              accept_s;

    // Raster position of the next pixel to be accepted
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;

    // Stage 1: the accepted pixel and what its position implies
    logic              acc1_q, acc1_d;
    logic              ok1_q, ok1_d;
    logic              last1_q, last1_d;
    logic [DATA_W-1:0] pix1_q, pix1_d;

    // Stage 2: window, start strobe, end-of-frame strobe
    logic [DATA_W-1:0] win_q [0:2][0:2];
    logic [DATA_W-1:0] win_d [0:2][0:2];
    logic              start_q, start_d;
    logic              frame_done_q, frame_done_d;

    // Line-buffer read data: lb0 holds row y-1, lb1 holds row y-2
    logic [DATA_W-1:0] lb0_old_s;
    logic [DATA_W-1:0] lb0_rd_s;
    logic [DATA_W-1:0] lb1_old_unused;
    logic [DATA_W-1:0] lb1_rd_s;

    assign accept_s = in_valid & ~rst;

    line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (DATA_W)
    ) u_lb0 (
        .clk     (clk),
        .rst     (rst),
        .en      (accept_s),
        .addr    (x_q),
        .wdata   (in_data),
        .rd_old  (lb0_old_s),
        .rd_data (lb0_rd_s)
    );

    // lb1 inherits the word lb0 is about to overwrite, one row older
    line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (DATA_W)
    ) u_lb1 (
        .clk     (clk),
        .rst     (rst),
        .en      (accept_s),
        .addr    (x_q),
        .wdata   (lb0_old_s),
        .rd_old  (lb1_old_unused),
        .rd_data (lb1_rd_s)
    );

    // Raster counters and stage-1 flags for the pixel being accepted
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        acc1_d  = accept_s;
        ok1_d   = 1'b0;
        last1_d = 1'b0;
        pix1_d  = pix1_q;
        if (accept_s) begin
            ok1_d   = (y_q >= Y_TWO) && (x_q >= X_TWO);
            last1_d = (y_q == Y_LAST) && (x_q == X_LAST);
            pix1_d  = in_data;
            if (x_q == X_LAST) begin
                x_d = {XW{1'b0}};
                if (y_q == Y_LAST) begin
                    y_d = {YW{1'b0}};
                end else begin
                    y_d = y_q + Y_ONE;
                end
            end else begin
                x_d = x_q + X_ONE;
            end
        end else begin
            x_d = x_q;
        end
    end

    // Counter and stage-1 registers
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= {XW{1'b0}};
            y_q     <= {YW{1'b0}};
            acc1_q  <= 1'b0;
            ok1_q   <= 1'b0;
            last1_q <= 1'b0;
            pix1_q  <= {DATA_W{1'b0}};
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            acc1_q  <= acc1_d;
            ok1_q   <= ok1_d;
            last1_q <= last1_d;
            pix1_q  <= pix1_d;
        end
    end

    // Window shift: new right column is (y-2,x), (y-1,x), (y,x)
    always_comb begin
        win_d        = win_q;
        start_d      = 1'b0;
        frame_done_d = 1'b0;
        if (acc1_q) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 2; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            win_d[0][2]  = lb1_rd_s;
            win_d[1][2]  = lb0_rd_s;
            win_d[2][2]  = pix1_q;
            start_d      = ok1_q;
            frame_done_d = ok1_q & last1_q;
        end else begin
            start_d      = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    // Window and strobe registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= {DATA_W{1'b0}};
                end
            end
            start_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            win_q        <= win_d;
            start_q      <= start_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign grad_p11   = win_q[0][0];
    assign grad_p12   = win_q[0][1];
    assign grad_p13   = win_q[0][2];
    assign grad_p21   = win_q[1][0];
    assign grad_p22   = win_q[1][1];
    assign grad_p23   = win_q[1][2];
    assign grad_p31   = win_q[2][0];
    assign grad_p32   = win_q[2][1];
    assign grad_p33   = win_q[2][2];
    assign start      = start_q;
    assign frame_done = frame_done_q;

endmodule
